cam_stream_gen: RTL and testbench



---
 rtl/cam_stream_gen.sv | 158 +++++++++++++++
 tb/tb_cam_stream_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic OV7670-style camera source for bring-up and simulation.
// Produces a vsync/href/d parallel stream (YUV422, byte order Y0 U Y1 V) on pclk
// with programmable frame/blanking geometry and four selectable test patterns.
//
// Ports:
//   pclk           in   pixel clock, all logic on the rising edge
//   reset          in   synchronous, active-high
//   enable_i       in   run request, only acted on at frame boundaries
//   pattern_sel_i  in   0 h-ramp, 1 checkerboard, 2 solid, 3 v-ramp
//   solid_y_i      in   luma for the solid pattern
//   vsync_o        out  frame sync, high for the first VSYNC_LINES lines
//   href_o         out  line valid; d_o is only meaningful while high
//   d_o            out  pixel byte (0 whenever href_o is low)
//   frame_done_o   out  one-cycle pulse on the final cycle of each frame
//   frame_count_o  out  completed frames, wraps 255 -> 0
module cam_stream_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [1:0] pattern_sel_i,
  input  logic [7:0] solid_y_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] d_o,
  output logic       frame_done_o,
  output logic [7:0] frame_count_o
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  // One extra count of headroom so every boundary constant fits the counter width.
  localparam int HW = $clog2(LINE_LEN + 1);
  localparam int VW = $clog2(FRAME_LINES + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] VS_END    = VW'(VSYNC_LINES);
  localparam logic [VW-1:0] AV_START  = VW'(VSYNC_LINES + V_BACK);
  localparam logic [VW-1:0] AV_END    = VW'(VSYNC_LINES + V_BACK + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [1:0]      pat_q;
  logic [7:0]      solid_q;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      d_q, d_d;
  logic            fdone_q, fdone_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic            run_d, av_d, start_d;
  logic [7:0]      x_d, y_d;

  function automatic logic [7:0] luma(input logic [1:0] sel, input logic [7:0] sy,
                                      input logic [7:0] x, input logic [7:0] y);
    logic [7:0] v;
    case (sel)
      2'd0:    v = x;
      2'd1:    v = (x[4] ^ y[4]) ? 8'hFF : 8'h00;
      2'd2:    v = sy;
      default: v = y;
    endcase
    return v;
  endfunction

  // Next position: raster counters and FSM
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (enable_i) state_d = RUN;
      end
      default: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          if (vcnt_q == V_LAST) begin
            vcnt_d = '0;
            // A frame always completes; enable only decides whether another follows.
            if (!enable_i) state_d = IDLE;
          end else begin
            vcnt_d = vcnt_q + VW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
    endcase
  end

  // Outputs are computed from the next position so the registered values line up
  // with the counters during the cycle they describe.
  always_comb begin
    run_d   = (state_d == RUN);
    start_d = run_d && (hcnt_d == '0) && (vcnt_d == '0);
    vsync_d = run_d && (vcnt_d < VS_END);
    av_d    = run_d && (vcnt_d >= AV_START) && (vcnt_d < AV_END);
    href_d  = av_d && (hcnt_d < H_ACT_END);
    x_d     = 8'(hcnt_d >> 1);
    y_d     = 8'(vcnt_d - AV_START);
    d_d     = 8'h00;
    if (href_d) d_d = hcnt_d[0] ? 8'h80 : luma(pat_q, solid_q, x_d, y_d);
    fdone_d = run_d && (hcnt_d == H_LAST) && (vcnt_d == V_LAST);
    fcnt_d  = fdone_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  // Registered control and output stage
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'h00;
      fdone_q <= 1'b0;
      fcnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      d_q     <= d_d;
      fdone_q <= fdone_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Pattern settings are frozen for a whole frame; the first active byte is
  // several lines after (0,0), so the freshly latched values are always in place.
  always_ff @(posedge pclk) begin
    if (start_d) begin
      pat_q   <= pattern_sel_i;
      solid_q <= solid_y_i;
    end
  end

  assign vsync_o       = vsync_q;
  assign href_o        = href_q;
  assign d_o           = d_q;
  assign frame_done_o  = fdone_q;
  assign frame_count_o = fcnt_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
module tb_cam_stream_gen;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, enable2 = 1'b0;
  logic [1:0] pattern_sel = 2'd0, pattern_sel2 = 2'd1;
  logic [7:0] solid_y = 8'h00;
  logic       vsync, href, frame_done, vsync2, href2, frame_done2;
  logic [7:0] d, frame_count, d2, frame_count2;

  int checks = 0;
  int errors = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  bit sb1_on = 1'b0;

  always #5 pclk = ~pclk;

  // Small geometry: LINE_LEN=10, 5 lines, 50-cycle frame
  cam_stream_gen #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .VSYNC_LINES(1),
                   .V_BACK(1), .V_FRONT(1)) dut (
    .pclk(pclk), .reset(reset), .enable_i(enable), .pattern_sel_i(pattern_sel),
    .solid_y_i(solid_y), .vsync_o(vsync), .href_o(href), .d_o(d),
    .frame_done_o(frame_done), .frame_count_o(frame_count));

  // Wider geometry for the checkerboard: 32 pixels, 17 active lines
  cam_stream_gen #(.H_ACTIVE(32), .V_ACTIVE(17), .H_BLANK(2), .VSYNC_LINES(1),
                   .V_BACK(1), .V_FRONT(1)) dut_chk (
    .pclk(pclk), .reset(reset), .enable_i(enable2), .pattern_sel_i(pattern_sel2),
    .solid_y_i(8'h00), .vsync_o(vsync2), .href_o(href2), .d_o(d2),
    .frame_done_o(frame_done2), .frame_count_o(frame_count2));

  typedef struct {
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, and feed the scoreboards.
  task automatic step();
    logic [7:0] e;
    @(posedge pclk);
    #1;
    if (sb1_on && href) begin
      if (q1.size() == 0) check("sb1_underflow", {24'h0, d}, 32'hFFFF_FFFF);
      else begin e = q1.pop_front(); check("sb1_byte", {24'h0, d}, {24'h0, e}); end
    end
    if (href2) begin
      if (q2.size() == 0) check("sb2_underflow", {24'h0, d2}, 32'hFFFF_FFFF);
      else begin e = q2.pop_front(); check("sb2_byte", {24'h0, d2}, {24'h0, e}); end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; enable2 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
  endtask

  // Enable in the current cycle t and check cycles t+1..t+40 against the table.
  task automatic run_ramp_table(input string tag);
    pattern_sel = 2'd0;
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check({tag, "_vsync"}, {31'h0, vsync}, {31'h0, tbl[k-1].vs});
      check({tag, "_href"},  {31'h0, href},  {31'h0, tbl[k-1].hr});
      check({tag, "_d"},     {24'h0, d},     {24'h0, tbl[k-1].d});
    end
  endtask

  task automatic push_small_frame(input logic [1:0] sel, input logic [7:0] sy);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) begin
        q1.push_back(sel == 2'd2 ? sy : 8'(y));
        q1.push_back(8'h80);
      end
  endtask

  initial begin
    logic [7:0] dl[8];
    logic [7:0] xb, yb;
    dl = '{8'h00, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03, 8'h80};
    for (int k = 1; k <= 40; k++) begin
      tbl[k-1].vs = (k <= 10);
      tbl[k-1].hr = 1'b0;
      tbl[k-1].d  = 8'h00;
      if (k >= 21 && k <= 28) begin tbl[k-1].hr = 1'b1; tbl[k-1].d = dl[k-21]; end
      if (k >= 31 && k <= 38) begin tbl[k-1].hr = 1'b1; tbl[k-1].d = dl[k-31]; end
    end

    // (1) reset and idle
    do_reset();
    check("rst_count", {24'h0, frame_count}, 32'h0);
    for (int k = 0; k < 100; k++) begin
      step();
      check("idle_vsync", {31'h0, vsync}, 32'h0);
      check("idle_href", {31'h0, href}, 32'h0);
      check("idle_d", {24'h0, d}, 32'h0);
      check("idle_fdone", {31'h0, frame_done}, 32'h0);
    end
    check("idle_count", {24'h0, frame_count}, 32'h0);

    // (2) horizontal ramp timing
    run_ramp_table("ramp");
    enable = 1'b0;

    // (3) checkerboard on the wide instance
    do_reset();
    for (int y = 0; y < 17; y++)
      for (int x = 0; x < 32; x++) begin
        xb = 8'(x); yb = 8'(y);
        q2.push_back((xb[4] ^ yb[4]) ? 8'hFF : 8'h00);
        q2.push_back(8'h80);
      end
    pattern_sel2 = 2'd1;
    enable2 = 1'b1;
    step();
    enable2 = 1'b0;
    for (int k = 0; k < 1330; k++) step();
    check("chk_sb_empty", q2.size(), 32'h0);
    check("chk_count", {24'h0, frame_count2}, 32'h1);

    // (4) solid pattern, solid_y changed mid-frame
    do_reset();
    push_small_frame(2'd2, 8'h5A);
    push_small_frame(2'd2, 8'h11);
    pattern_sel = 2'd2; solid_y = 8'h5A; sb1_on = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      step();
      if (k == 25) solid_y = 8'h11;
      if (k == 51) enable = 1'b0;
    end
    check("solid_sb_empty", q1.size(), 32'h0);
    check("solid_count", {24'h0, frame_count}, 32'h2);
    sb1_on = 1'b0;

    // vertical ramp, one frame
    do_reset();
    push_small_frame(2'd3, 8'h00);
    pattern_sel = 2'd3; sb1_on = 1'b1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 0; k < 55; k++) step();
    check("vramp_sb_empty", q1.size(), 32'h0);
    sb1_on = 1'b0;

    // (5) enable dropped mid-frame
    do_reset();
    pattern_sel = 2'd0;
    enable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 5) enable = 1'b0;
      check("drop_fdone", {31'h0, frame_done}, {31'h0, (k == 50)});
      if (k >= 51) begin
        check("drop_idle_vsync", {31'h0, vsync}, 32'h0);
        check("drop_idle_href", {31'h0, href}, 32'h0);
        check("drop_idle_d", {24'h0, d}, 32'h0);
      end
    end
    check("drop_count", {24'h0, frame_count}, 32'h1);
    enable = 1'b1;
    step();
    check("reenable_vsync", {31'h0, vsync}, 32'h1);
    check("reenable_href", {31'h0, href}, 32'h0);

    // (6) reset mid active line of the second frame
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 74; k++) step();
    check("midrst_pre_href", {31'h0, href}, 32'h1);
    check("midrst_pre_d", {24'h0, d}, 32'h80);
    check("midrst_pre_count", {24'h0, frame_count}, 32'h1);
    reset = 1'b1; enable = 1'b0;
    step();
    check("midrst_vsync", {31'h0, vsync}, 32'h0);
    check("midrst_href", {31'h0, href}, 32'h0);
    check("midrst_d", {24'h0, d}, 32'h0);
    check("midrst_fdone", {31'h0, frame_done}, 32'h0);
    check("midrst_count", {24'h0, frame_count}, 32'h0);
    reset = 1'b0;
    step();
    step();
    check("midrst_idle_vsync", {31'h0, vsync}, 32'h0);
    run_ramp_table("restart");
    enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
